// File: rtl/sample_fetch_pkg.sv
// ----------------------------------------------------------------------------
// sample_fetch_pkg
// Shared definitions for the sample_fetch request server:
//   - default widths for request address / id, derived from the
//     REQ_ADDR_SIZE_U / REQ_ID_SIZE_U upper-bit indices
//   - request queue depth default
//   - RAM wait limit default (only meaningful when FETCH_TIMEOUT_EN is defined)
//   - fetch FSM state encoding
// ----------------------------------------------------------------------------
package sample_fetch_pkg;

    // Upper bit indices of the request address and id fields.
    localparam int REQ_ADDR_SIZE_U = 23;
    localparam int REQ_ID_SIZE_U   = 4;

    localparam int ADDR_W_DEF         = REQ_ADDR_SIZE_U + 1;
    localparam int ID_W_DEF           = REQ_ID_SIZE_U + 1;
    localparam int FIFO_DEPTH_DEF     = 8;
    localparam int TIMEOUT_CYCLES_DEF = 1024;

    // Fetch FSM: one RAM read in flight at a time.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,  // waiting for a queued request
        ST_ISSUE  = 2'd1,  // presenting mem_rd_req until the RAM acks
        ST_WAIT   = 2'd2,  // waiting for mem_rd_valid
        ST_RETURN = 2'd3   // handing the word back to playback
    } fetch_state_e;

endpackage : sample_fetch_pkg

// File: rtl/fetch_req_fifo.sv
// ----------------------------------------------------------------------------
// fetch_req_fifo
// Synchronous request queue for sample_fetch.
//
// Pointers carry one extra wrap bit: equal pointers mean empty, pointers that
// differ only in the wrap bit mean full. A push while full is accepted only
// when a pop happens on the same edge (the freed slot is the one written).
//
// Ports:
//   clk    in   system clock
//   reset  in   synchronous active-low reset (empties the queue)
//   push   in   write request
//   wdata  in   [WIDTH-1:0] entry to write
//   pop    in   read request (ignored when empty)
//   rdata  out  [WIDTH-1:0] head entry (valid when !empty)
//   full   out  queue holds DEPTH entries
//   empty  out  queue holds no entries
//
// DEPTH must be a power of two, at least 2.
// ----------------------------------------------------------------------------
module fetch_req_fifo #(
    parameter int WIDTH = 29,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q + {{PTR_W{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{PTR_W{1'b0}}, do_pop};
        rdata    = mem_q[rd_ptr_q[PTR_W-1:0]];
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define which
    // entries are valid, so clearing the array would only cost logic.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= wdata;
        end
    end

endmodule : fetch_req_fifo

// File: rtl/sample_fetch.sv
// ----------------------------------------------------------------------------
// sample_fetch
// Memory-side request server upstream of playback. Queues playback's sample
// read requests, issues them one at a time to the sample RAM read port and
// returns each 16-bit word tagged with its request id, in request order.
//
// Ports:
//   clk            in   200 MHz system clock
//   reset          in   synchronous active-low reset
//   req_available  in   request strobe, one request per high cycle
//   address_in     in   [ADDR_W-1:0] request word address
//   r_id_in        in   [ID_W-1:0]   request id
//   data_out       out  [15:0]       returned sample word (held after strobe)
//   r_id_out       out  [ID_W-1:0]   id of the returned word (held)
//   data_ready     out  one-cycle strobe: data_out / r_id_out valid
//   mem_addr       out  [ADDR_W-1:0] RAM read address
//   mem_rd_req     out  RAM read request, held until mem_rd_ack
//   mem_rd_ack     in   RAM accepted mem_addr
//   mem_rd_valid   in   RAM read data valid (one cycle)
//   mem_rd_data    in   [15:0]       RAM read data
//   busy           out  queue non-empty or FSM not idle
//   overflow       out  sticky: a request was dropped on a full queue
//   timeout_err    out  sticky: a RAM read timed out (FETCH_TIMEOUT_EN only)
//
// Build option FETCH_TIMEOUT_EN: when defined, a read that sees no
// mem_rd_valid within TIMEOUT_CYCLES of entering WAIT is returned as
// 16'h0000 with its id and timeout_err is set. When undefined, WAIT waits
// indefinitely and the timeout_err port does not exist.
//
// Returned data leaves through registers, so data_ready rises on the edge
// that ends RETURN: a request sampled at edge N appears after edge N+4 when
// the RAM acks on the first ISSUE cycle and returns data one cycle later.
// ----------------------------------------------------------------------------
module sample_fetch
    import sample_fetch_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int ID_W       = ID_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
`ifdef FETCH_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_available,
    input  logic [ADDR_W-1:0] address_in,
    input  logic [ID_W-1:0]   r_id_in,
    output logic [15:0]       data_out,
    output logic [ID_W-1:0]   r_id_out,
    output logic              data_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_req,
    input  logic              mem_rd_ack,
    input  logic              mem_rd_valid,
    input  logic [15:0]       mem_rd_data,
    output logic              busy,
    output logic              overflow
`ifdef FETCH_TIMEOUT_EN
    ,
    output logic              timeout_err
`endif
);

    localparam int ENTRY_W = ADDR_W + ID_W;

    fetch_state_e        state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [15:0]         rdata_q, rdata_d;
    logic [15:0]         data_out_q, data_out_d;
    logic [ID_W-1:0]     r_id_out_q, r_id_out_d;
    logic                data_ready_q, data_ready_d;
    logic                overflow_q, overflow_d;

    logic                fifo_pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [ENTRY_W-1:0]  fifo_rdata;

`ifdef FETCH_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic                timeout_err_q, timeout_err_d;
`endif

    // ------------------------------------------------------------------------
    // Request queue. Entries are {address, id}; the queue itself refuses a
    // push when full unless the FSM pops on the same edge.
    // ------------------------------------------------------------------------
    fetch_req_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (req_available),
        .wdata ({address_in, r_id_in}),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // ------------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        id_d         = id_q;
        rdata_d      = rdata_q;
        data_out_d   = data_out_q;
        r_id_out_d   = r_id_out_q;
        data_ready_d = 1'b0;
        fifo_pop     = 1'b0;
        mem_rd_req   = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        tmo_cnt_d     = tmo_cnt_q;
        timeout_err_d = timeout_err_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    addr_d   = fifo_rdata[ENTRY_W-1:ID_W];
                    id_d     = fifo_rdata[ID_W-1:0];
                    state_d  = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                mem_rd_req = 1'b1;
                if (mem_rd_ack) begin
                    state_d = ST_WAIT;
`ifdef FETCH_TIMEOUT_EN
                    tmo_cnt_d = '0;
`endif
                end
            end

            ST_WAIT: begin
                // Real data wins over a timeout landing on the same cycle.
                if (mem_rd_valid) begin
                    rdata_d = mem_rd_data;
                    state_d = ST_RETURN;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    rdata_d       = 16'h0000;
                    timeout_err_d = 1'b1;
                    state_d       = ST_RETURN;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
`endif
            end

            ST_RETURN: begin
                data_ready_d = 1'b1;
                data_out_d   = rdata_q;
                r_id_out_d   = id_q;
                state_d      = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase

        // A request is lost only if the queue is full and nothing leaves it
        // on this edge.
        overflow_d = overflow_q | (req_available & fifo_full & ~fifo_pop);
    end

    // ------------------------------------------------------------------------
    // State registers. Reset returns to IDLE, which also abandons any RAM
    // read in flight: a late mem_rd_valid is ignored outside WAIT.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            id_q         <= '0;
            rdata_q      <= '0;
            data_out_q   <= '0;
            r_id_out_q   <= '0;
            data_ready_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            id_q         <= id_d;
            rdata_q      <= rdata_d;
            data_out_q   <= data_out_d;
            r_id_out_q   <= r_id_out_d;
            data_ready_q <= data_ready_d;
            overflow_q   <= overflow_d;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            tmo_cnt_q     <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            tmo_cnt_q     <= tmo_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`endif

    assign data_out   = data_out_q;
    assign r_id_out   = r_id_out_q;
    assign data_ready = data_ready_q;
    assign mem_addr   = addr_q;
    assign overflow   = overflow_q;
    assign busy       = (state_q != ST_IDLE) || !fifo_empty;

endmodule : sample_fetch

// File: tb/tb_sample_fetch.sv
// ----------------------------------------------------------------------------
// tb_sample_fetch
// Directed self-checking bench for sample_fetch. A small RAM responder acks
// read requests (when enabled) and returns a word a configurable number of
// cycles after the ack; a collector records every data_ready strobe.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled
// at the same point, away from the active edge.
// ----------------------------------------------------------------------------
module tb_sample_fetch;
    import sample_fetch_pkg::*;

    localparam int AW = ADDR_W_DEF;
    localparam int IW = ID_W_DEF;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_available;
    logic [AW-1:0] address_in;
    logic [IW-1:0] r_id_in;
    logic [15:0]   data_out;
    logic [IW-1:0] r_id_out;
    logic          data_ready;
    logic [AW-1:0] mem_addr;
    logic          mem_rd_req;
    logic          mem_rd_ack;
    logic          mem_rd_valid;
    logic [15:0]   mem_rd_data;
    logic          busy;
    logic          overflow;
`ifdef FETCH_TIMEOUT_EN
    logic          timeout_err;
`endif

    int errors = 0;
    int checks = 0;

    // RAM responder controls
    bit ack_en   = 1'b1;
    bit valid_en = 1'b1;
    int ram_lat  = 1;

    typedef struct {
        logic [15:0]   d;
        logic [IW-1:0] id;
    } ret_t;
    ret_t got[$];

    always #5 clk = ~clk;

    sample_fetch #(
        .ADDR_W     (AW),
        .ID_W       (IW),
        .FIFO_DEPTH (8)
`ifdef FETCH_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (16)
`endif
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_available (req_available),
        .address_in    (address_in),
        .r_id_in       (r_id_in),
        .data_out      (data_out),
        .r_id_out      (r_id_out),
        .data_ready    (data_ready),
        .mem_addr      (mem_addr),
        .mem_rd_req    (mem_rd_req),
        .mem_rd_ack    (mem_rd_ack),
        .mem_rd_valid  (mem_rd_valid),
        .mem_rd_data   (mem_rd_data),
        .busy          (busy),
        .overflow      (overflow)
`ifdef FETCH_TIMEOUT_EN
        ,
        .timeout_err   (timeout_err)
`endif
    );

    // RAM contents as seen by the bench.
    function automatic logic [15:0] ram_word(input logic [AW-1:0] a);
        return (a == 24'h000064) ? 16'h1234 : (a[15:0] ^ 16'hBEEF);
    endfunction

    // RAM responder: acks a pending mem_rd_req, then drives mem_rd_valid
    // ram_lat cycles after the ack cycle.
    initial begin
        int            cnt;
        bit            pend;
        logic [AW-1:0] a;
        mem_rd_ack   = 1'b0;
        mem_rd_valid = 1'b0;
        mem_rd_data  = '0;
        cnt  = 0;
        pend = 1'b0;
        a    = '0;
        forever begin
            @(negedge clk);
            mem_rd_ack   = 1'b0;
            mem_rd_valid = 1'b0;
            if (pend) begin
                if (!valid_en) begin
                    pend = 1'b0;
                end else if (cnt <= 1) begin
                    mem_rd_valid = 1'b1;
                    mem_rd_data  = ram_word(a);
                    pend = 1'b0;
                end else begin
                    cnt--;
                end
            end else if (mem_rd_req && ack_en) begin
                mem_rd_ack = 1'b1;
                a    = mem_addr;
                cnt  = ram_lat;
                pend = 1'b1;
            end
        end
    end

    // Collector: every data_ready strobe is recorded.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (data_ready) got.push_back('{d: data_out, id: r_id_out});
        end
    end

    // Hard stop if the sequence ever stalls.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, summary not reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_burst(input logic [AW-1:0] base, input int first_id, input int n);
        for (int i = 0; i < n; i++) begin
            req_available = 1'b1;
            address_in    = base + AW'(i);
            r_id_in       = IW'(first_id + i);
            tick(1);
        end
        req_available = 1'b0;
    endtask

    task automatic wait_req(input logic level, input int lim, input string tag);
        for (int c = 0; c < lim && mem_rd_req !== level; c++) tick(1);
        check(tag, {31'd0, mem_rd_req}, {31'd0, level});
    endtask

    task automatic wait_returns(input int n, input int lim, input string tag);
        for (int c = 0; c < lim && got.size() < n; c++) tick(1);
        tick(20);  // any extra strobe would show up here
        check(tag, got.size(), n);
    endtask

    initial begin
        reset         = 1'b0;
        req_available = 1'b0;
        address_in    = '0;
        r_id_in       = '0;

        // ---------------- reset state ----------------
        tick(3);
        check("rst_data_ready", {31'd0, data_ready}, 0);
        check("rst_mem_rd_req", {31'd0, mem_rd_req}, 0);
        check("rst_busy",       {31'd0, busy}, 0);
        check("rst_overflow",   {31'd0, overflow}, 0);
        reset = 1'b1;
        tick(2);

        // ---------------- single request, minimum latency ----------------
        ram_lat = 1;
        req_available = 1'b1;
        address_in    = 24'h000064;
        r_id_in       = 5'd3;
        tick(1);                        // edge N
        req_available = 1'b0;
        tick(3);                        // edge N+3
        check("t1_dr_n3",   {31'd0, data_ready}, 0);
        check("t1_busy_n3", {31'd0, busy}, 1);
        tick(1);                        // edge N+4
        check("t1_dr_n4",   {31'd0, data_ready}, 1);
        check("t1_data",    {16'd0, data_out}, 32'h1234);
        check("t1_id",      {27'd0, r_id_out}, 3);
        check("t1_busy_n4", {31'd0, busy}, 0);
        tick(1);
        check("t1_dr_drop", {31'd0, data_ready}, 0);
        check("t1_hold",    {16'd0, data_out}, 32'h1234);

        // ---------------- 8 back-to-back, RAM latency 5 ----------------
        got.delete();
        ram_lat = 5;
        push_burst(24'h000100, 0, 8);
        wait_returns(8, 400, "t2_count");
        for (int i = 0; i < 8; i++) begin
            if (got.size() > i) begin
                check($sformatf("t2_id%0d", i),   {27'd0, got[i].id}, i);
                check($sformatf("t2_data%0d", i), {16'd0, got[i].d},
                      {16'd0, ram_word(24'h000100 + AW'(i))});
            end
        end
        check("t2_overflow", {31'd0, overflow}, 0);
        check("t2_busy",     {31'd0, busy}, 0);

        // ---------------- overflow while RAM withholds ack ----------------
        ack_en  = 1'b0;
        ram_lat = 2;
        push_burst(24'h000200, 20, 1);   // blocker held in ISSUE
        wait_req(1'b1, 20, "t3_req_high");
        check("t3_mem_addr", {8'd0, mem_addr}, 32'h000200);
        push_burst(24'h000300, 0, 10);   // ids 8 and 9 must be dropped
        check("t3_overflow", {31'd0, overflow}, 1);
        check("t3_busy",     {31'd0, busy}, 1);
        got.delete();
        ack_en = 1'b1;
        wait_returns(9, 300, "t3_count");
        if (got.size() > 0) check("t3_blocker_id", {27'd0, got[0].id}, 20);
        for (int i = 0; i < 8; i++) begin
            if (got.size() > i + 1) begin
                check($sformatf("t3_id%0d", i),   {27'd0, got[i+1].id}, i);
                check($sformatf("t3_data%0d", i), {16'd0, got[i+1].d},
                      {16'd0, ram_word(24'h000300 + AW'(i))});
            end
        end
        check("t3_overflow_sticky", {31'd0, overflow}, 1);

        // ---------------- reset clears everything ----------------
        reset = 1'b0;
        tick(2);
        check("r_data_out",   {16'd0, data_out}, 0);
        check("r_r_id_out",   {27'd0, r_id_out}, 0);
        check("r_data_ready", {31'd0, data_ready}, 0);
        check("r_mem_addr",   {8'd0, mem_addr}, 0);
        check("r_overflow",   {31'd0, overflow}, 0);
        check("r_busy",       {31'd0, busy}, 0);
        reset = 1'b1;
        tick(1);

        // ---------------- reset during WAIT, late valid ignored ----------------
        ram_lat = 8;
        push_burst(24'h000400, 9, 1);
        wait_req(1'b1, 20, "t4_req_high");
        wait_req(1'b0, 20, "t4_in_wait");
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        got.delete();
        tick(20);                        // valid arrives in here
        check("t4_no_return",  got.size(), 0);
        check("t4_data_ready", {31'd0, data_ready}, 0);
        check("t4_data_out",   {16'd0, data_out}, 0);
        check("t4_mem_rd_req", {31'd0, mem_rd_req}, 0);
        check("t4_busy",       {31'd0, busy}, 0);

        // ---------------- push on the edge a full queue pops ----------------
        ram_lat = 1;
        ack_en  = 1'b0;
        push_burst(24'h000500, 21, 1);
        wait_req(1'b1, 20, "t5_req_high");
        push_burst(24'h000600, 0, 8);    // queue now exactly full
        check("t5_full_no_drop", {31'd0, overflow}, 0);
        got.delete();
        ack_en = 1'b1;
        // data_ready is high in the IDLE cycle that pops the full queue
        for (int c = 0; c < 30 && !data_ready; c++) tick(1);
        check("t5_dr_seen", {31'd0, data_ready}, 1);
        req_available = 1'b1;
        address_in    = 24'h000608;
        r_id_in       = 5'd8;
        tick(1);
        req_available = 1'b0;
        check("t5_overflow_edge", {31'd0, overflow}, 0);
        wait_returns(10, 300, "t5_count");
        if (got.size() > 0) check("t5_blocker_id", {27'd0, got[0].id}, 21);
        for (int i = 0; i < 9; i++) begin
            if (got.size() > i + 1) begin
                check($sformatf("t5_id%0d", i),   {27'd0, got[i+1].id}, i);
                check($sformatf("t5_data%0d", i), {16'd0, got[i+1].d},
                      {16'd0, ram_word(24'h000600 + AW'(i))});
            end
        end
        check("t5_overflow_end", {31'd0, overflow}, 0);

`ifdef FETCH_TIMEOUT_EN
        // ---------------- RAM never returns data ----------------
        begin
            int cyc;
            reset = 1'b0;
            tick(2);
            reset = 1'b1;
            check("t6_tmo_rst", {31'd0, timeout_err}, 0);
            valid_en = 1'b0;
            ack_en   = 1'b1;
            push_burst(24'h000700, 5, 1);
            wait_req(1'b1, 20, "t6_req_high");
            wait_req(1'b0, 20, "t6_in_wait");   // edge of WAIT entry
            cyc = 0;
            for (int c = 0; c < 60 && !data_ready; c++) begin
                tick(1);
                cyc++;
            end
            // 16 WAIT cycles, one RETURN cycle, then the registered strobe
            check("t6_latency",   cyc, 17);
            check("t6_data_ready", {31'd0, data_ready}, 1);
            check("t6_data",      {16'd0, data_out}, 0);
            check("t6_id",        {27'd0, r_id_out}, 5);
            check("t6_tmo_err",   {31'd0, timeout_err}, 1);
            valid_en = 1'b1;
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_sample_fetch
